// File: rtl/cache_pkg.sv
// Shared types and default sizes for the cache refill controller.
package cache_pkg;

  localparam int unsigned TAG_W_DEF   = 36;
  localparam int unsigned INDEX_W_DEF = 8;
  localparam int unsigned WORDS_DEF   = 4;
  localparam int unsigned DATA_W_DEF  = 32;

  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned WAY_W    = 2;

  typedef logic [WAY_W-1:0] way_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/victim_select.sv
// Victim way choice: lowest invalid way, else the round-robin pointer.
module victim_select
  import cache_pkg::*;
(
  input  logic [NUM_WAYS-1:0] i_valid_bits,
  input  way_t                i_rr_ptr,
  output way_t                o_way,
  output logic                o_from_rr
);

  // Scan from the top down so the lowest-numbered invalid way wins.
  always_comb begin
    o_way     = i_rr_ptr;
    o_from_rr = 1'b1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!i_valid_bits[i]) begin
        o_way     = way_t'(i);
        o_from_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: requests a block from memory, streams the
// returned words into the data array, then writes the tag of the victim way.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned WORDS   = WORDS_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [TAG_W-1:0]           req_tag,
  input  logic [INDEX_W-1:0]         req_index,
  input  logic                       hit,
  input  logic [NUM_WAYS-1:0]        valid_bits,
  output logic                       stall,
  output logic                       mem_req,
  output logic [TAG_W+INDEX_W-1:0]   mem_addr,
  input  logic                       mem_ack,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       data_we,
  output way_t                       data_way,
  output logic [$clog2(WORDS)-1:0]   data_word,
  output logic [DATA_W-1:0]          data_wdata,
  output logic                       tag_we,
  output way_t                       tag_way,
  output logic [INDEX_W-1:0]         tag_index,
  output logic [TAG_W-1:0]           tag_wdata
);

  localparam int unsigned WORD_W = $clog2(WORDS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  way_t                r_victim;
  logic                r_victim_rr;
  way_t                r_rr_ptr;
  logic [WORD_W-1:0]   r_beat;

  way_t                w_sel_way;
  logic                w_sel_from_rr;
  logic                w_miss;
  logic                w_last_beat;

  victim_select u_victim_select (
    .i_valid_bits (valid_bits),
    .i_rr_ptr     (r_rr_ptr),
    .o_way        (w_sel_way),
    .o_from_rr    (w_sel_from_rr)
  );

  assign w_miss      = req_valid && !hit;
  assign w_last_beat = (r_beat == WORD_W'(WORDS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss && !reset) begin
          stall       = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          data_we = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        stall       = 1'b1;
        tag_we      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Miss context, beat counter and replacement pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag       <= '0;
      r_index     <= '0;
      r_victim    <= '0;
      r_victim_rr <= 1'b0;
      r_rr_ptr    <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_tag       <= req_tag;
            r_index     <= req_index;
            r_victim    <= w_sel_way;
            r_victim_rr <= w_sel_from_rr;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_beat <= '0;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + WORD_W'(1);
          end
        end
        ST_COMMIT: begin
          if (r_victim_rr) begin
            r_rr_ptr <= r_rr_ptr + way_t'(1);
          end
        end
        default: begin
          r_beat <= '0;
        end
      endcase
    end
  end

  assign mem_addr   = {r_tag, r_index};
  assign data_way   = r_victim;
  assign data_word  = r_beat;
  assign data_wdata = mem_rdata;
  assign tag_way    = r_victim;
  assign tag_index  = r_index;
  assign tag_wdata  = r_tag;

endmodule
